// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, pc step and default reset address for pipe_ctrl
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {PC_ST_RUN, PC_ST_HOLD, PC_ST_FLUSH} pc_state_e;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
  function automatic logic [31:0] align_target(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction
endpackage

// File: rtl/pipe_ctrl_pc_reg.sv
// pipe_ctrl_pc_reg: program counter register with load, increment and hold
module pipe_ctrl_pc_reg
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = PC_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        inc,
  output logic [31:0] pc
);
  // load wins over increment; neither means hold
  always_ff @(posedge clk)
    if (rst) pc <= RESET_ADDR;
    else if (load) pc <= target;
    else if (inc) pc <= pc + PC_STEP;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pc owner sequencing redirect flush bubbles and stalls; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR   = PC_RESET_ADDR,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        hold_bus_i,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        misalign_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);
  localparam logic [2:0] LAST = 3'(FLUSH_CYCLES == 0 ? 0 : FLUSH_CYCLES - 1);
  pc_state_e  state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       accept, in_flush, inc, cnt_done;
  pipe_ctrl_pc_reg #(.RESET_ADDR(RESET_ADDR)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .target (align_target(jump_addr_i)),
    .inc    (inc),
    .pc     (pc_o)
  );
  // state, bubble counter and misalign pulse registers
  always_ff @(posedge clk)
    if (rst) begin
      state      <= PC_ST_RUN;
      cnt        <= '0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      misalign_o <= accept & jump_addr_i[1];
    end
  // HOLD resolves exactly like RUN once the stall clears, so both share one path
  always_comb begin
    stall_o    = hold_flag_i | hold_bus_i;
    in_flush   = state == PC_ST_FLUSH;
    accept     = jump_en_i & ~stall_o & ~in_flush;
    flush_o    = in_flush | accept;
    inc        = in_flush ? ~hold_bus_i : ~stall_o & ~accept;
    cnt_done   = in_flush & ~hold_bus_i & (cnt == LAST);
    cnt_next   = (in_flush & ~hold_bus_i) ? (cnt_done ? 3'd0 : cnt + 3'd1) : cnt;
    state_next = in_flush ? (cnt_done ? PC_ST_RUN : PC_ST_FLUSH) :
                 stall_o ? PC_ST_HOLD :
                 (accept && FLUSH_CYCLES > 0) ? PC_ST_FLUSH : PC_ST_RUN;
  end
  // execute must present a bubble while redirect bubbles drain
  always_ff @(posedge clk)
    if (!rst && state == PC_ST_FLUSH) assert (!jump_en_i);
`ifdef PIPE_CTRL_PERF_EN
  // saturating cycle counters for flush and stall activity
  always_ff @(posedge clk)
    if (rst) begin
      perf_flush_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (flush_o && perf_flush_cnt_o != '1) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      if (stall_o && perf_stall_cnt_o != '1) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; honours PIPE_CTRL_PERF_EN
module tb_pipe_ctrl;
  localparam logic [31:0] RA = 32'h0000_0000;
  localparam int FC = 1;
  typedef struct {
    logic [31:0] pc;
    logic        flush, stall, mis;
    logic [31:0] pf, ps;
  } exp_t;
  logic clk = 0, rst = 1, jump_en_i = 0, hold_flag_i = 0, hold_bus_i = 0;
  logic [31:0] jump_addr_i = 0, pc_o;
  logic flush_o, stall_o, misalign_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_flush_cnt_o, perf_stall_cnt_o;
`endif
  int n_cmp = 0, n_bad = 0;
  exp_t q[$];
  logic [31:0] m_pc = RA, m_pf = 0, m_ps = 0;
  int m_left = 0;
  logic m_mis = 0;

  pipe_ctrl #(.RESET_ADDR(RA), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .hold_bus_i(hold_bus_i), .pc_o(pc_o),
    .flush_o(flush_o), .stall_o(stall_o), .misalign_o(misalign_o)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_flush_cnt_o(perf_flush_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle of stimulus: expected outputs for this cycle go to the scoreboard,
  // then the reference advances to the values the next cycle must show
  task automatic step(input logic r, input logic hf, input logic hb, input logic je, input logic [31:0] ja);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    rst = r; hold_flag_i = hf; hold_bus_i = hb; jump_en_i = je; jump_addr_i = ja;
    if (r) begin
      m_pc = RA; m_left = 0; m_mis = 0; m_pf = 0; m_ps = 0;
      return;
    end
    acc = je && !(hf || hb) && m_left == 0;
    e.pc = m_pc; e.stall = hf | hb; e.flush = (m_left > 0) || acc;
    e.mis = m_mis; e.pf = m_pf; e.ps = m_ps;
    q.push_back(e);
    if (e.flush && m_pf != 32'hFFFF_FFFF) m_pf++;
    if (e.stall && m_ps != 32'hFFFF_FFFF) m_ps++;
    m_mis = acc && ja[1];
    if (m_left > 0) begin
      if (!hb) begin m_pc += 4; m_left--; end
    end else if (hf || hb) begin
    end else if (acc) begin
      m_pc = ja & ~32'd1; m_left = FC;
    end else m_pc += 4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // monitor: every non-reset cycle presents outputs; pop and compare
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc_o, e.pc);
      chk("flush", {31'd0, flush_o}, {31'd0, e.flush});
      chk("stall", {31'd0, stall_o}, {31'd0, e.stall});
      chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_flush", perf_flush_cnt_o, e.pf);
      chk("perf_stall", perf_stall_cnt_o, e.ps);
`endif
    end

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 32'h101);
    idle(3);
    step(0, 0, 0, 1, 32'h1C);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 32'h40);
    step(0, 0, 0, 1, 32'h40);
    idle(2);
    step(0, 0, 0, 1, 32'h202);
    idle(3);
    step(0, 0, 0, 1, 32'h300);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 32'h400);
    step(1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 32'hFFFF_FFF8);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      logic r, hf, hb, je;
      r  = ($urandom_range(0, 63) == 0);
      hf = ($urandom_range(0, 4) == 0);
      hb = ($urandom_range(0, 5) == 0);
      je = !r && m_left == 0 && ($urandom_range(0, 3) == 0);
      step(r, hf, hb, je, $urandom());
    end
    step(0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
